data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 The block SHALL have a parameter ADDR_W, default 10, setting the memory to 2^ADDR_W 32-bit words.
REQ-002 The block SHALL have a parameter BASE, default 32'h0000_0000, giving the byte base address of the memory window; bits [ADDR_W+1:0] of BASE are ignored.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port data_sram_en, input, 1, the access request for the current cycle.
REQ-006 The block SHALL have port data_sram_wen, input, 4, the byte-lane write enables; lane i is wdata[8i+7:8i]; all-zero means read.
REQ-007 The block SHALL have port data_sram_addr, input, 32, the byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have port data_sram_wdata, input, 32, the store data, already lane-aligned by the initiator.
REQ-009 The block SHALL have port data_sram_rdata, output, 32, the registered read data.
REQ-010 The block SHALL have port addr_err, output, 1, a sticky out-of-window access flag.
REQ-011 The block SHALL have port err_addr, output, 32, the byte address of the first out-of-window access.
REQ-012 The block SHALL have ports rd_cnt and wr_cnt, output, 16 each, counting completed in-window reads and writes.

Function
REQ-013 Word index SHALL be addr[ADDR_W+1:2]; an access is in-window iff addr[31:ADDR_W+2] == BASE[31:ADDR_W+2].
REQ-014 An access SHALL be sampled at a rising clk edge when data_sram_en=1 and rst=0; with en=0, no state changes and rdata holds.
REQ-015 Write (en=1, wen!=0, in-window): each lane with wen[i]=1 SHALL be updated at that edge; lanes with wen[i]=0 SHALL keep their value.
REQ-016 On a write cycle data_sram_rdata SHALL hold its previous value.
REQ-017 Read (en=1, wen=0, in-window): data_sram_rdata SHALL take mem[index] at that edge, so it is valid in the cycle after the request (latency 1), then hold until the next read.
REQ-018 A read in the cycle directly following a write to the same word SHALL return the newly written data.
REQ-019 Back-to-back reads on consecutive cycles SHALL each return their word one cycle later, with no bubbles.
REQ-020 An out-of-window access SHALL NOT modify memory; if a read, rdata SHALL become 32'h0; if a write, rdata holds.
REQ-021 On the first out-of-window access after reset, addr_err SHALL go to 1 and err_addr SHALL capture data_sram_addr; later errors SHALL NOT change err_addr.
REQ-022 rd_cnt and wr_cnt SHALL increment by 1 per in-window read and write respectively, saturating at 16'hFFFF.
REQ-023 Out-of-window accesses SHALL NOT increment either counter.

Reset
REQ-024 While rst=1, data_sram_rdata=0, addr_err=0, err_addr=0, rd_cnt=0 and wr_cnt=0 SHALL hold immediately, independent of clk.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 Any access presented while rst=1, including one at the edge where rst deasserts, SHALL be ignored: no memory write, no counter change.
REQ-027 The first access honoured SHALL be at the first rising edge with rst sampled low.

Verification
REQ-028 Write 32'hDEADBEEF to 32'h0000_0010 with wen=4'hF, then read 0x10 -> rdata=32'hDEADBEEF one cycle after the read; wr_cnt=1, rd_cnt=1.
REQ-029 Preload 0x10=32'hDEADBEEF; write wdata=32'h0000_5500 with wen=4'b0010 to addr 0x11, then read 0x10 -> rdata=32'hDEAD55EF.
REQ-030 Read 0x0, 0x4, 0x8 on three consecutive cycles with preloaded values 1, 2, 3 -> rdata=1, 2, 3 on the following three cycles.
REQ-031 With ADDR_W=10, BASE=0: read 32'h0000_1000, then write 32'h0000_2000 -> rdata=0 after the read; addr_err=1; err_addr=32'h0000_1000; memory unchanged; counters unchanged.
REQ-032 Assert rst asynchronously mid-cycle while a write to 0x20 is presented -> all outputs zero immediately; after rst release, reading 0x20 returns its pre-reset contents.
REQ-033 Issue 65536 in-window reads, then one more -> rd_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/data_sram_resp.sv
// ============================================================================
// data_sram_resp : single-port 32-bit data SRAM with byte-lane writes and
//                  1-cycle read latency, address-window check and counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_sram_resp #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        addr_err,
  output logic [31:0] err_addr,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int          c_DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [31:0]       r_mem [c_DEPTH];
  logic [31:0]       r_rdata;
  logic              r_addr_err;
  logic [31:0]       r_err_addr;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wr_cnt;

  logic [ADDR_W-1:0] w_idx;
  logic              w_in_win;
  logic              w_is_rd;
  logic              w_mem_wr;
  logic [1:0]        w_unused_addr_bits;

  assign w_idx              = data_sram_addr[ADDR_W+1:2];
  assign w_in_win           = (data_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
  assign w_is_rd            = (data_sram_wen == 4'h0);
  assign w_mem_wr           = data_sram_en && !w_is_rd && w_in_win;
  assign w_unused_addr_bits = data_sram_addr[1:0];

  // Storage is deliberately not reset; rst only blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata    <= 32'h0;
      r_addr_err <= 1'b0;
      r_err_addr <= 32'h0;
      r_rd_cnt   <= 16'h0;
      r_wr_cnt   <= 16'h0;
    end else if (data_sram_en) begin
      if (w_in_win) begin
        if (w_is_rd) begin
          r_rdata <= r_mem[w_idx];
          if (r_rd_cnt != c_CNT_MAX) r_rd_cnt <= r_rd_cnt + 16'd1;
        end else begin
          if (r_wr_cnt != c_CNT_MAX) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
      end else begin
        if (w_is_rd) r_rdata <= 32'h0;
        // Only the first offending address is kept.
        if (!r_addr_err) begin
          r_addr_err <= 1'b1;
          r_err_addr <= data_sram_addr;
        end
      end
    end
  end

  assign data_sram_rdata = r_rdata;
  assign addr_err        = r_addr_err;
  assign err_addr        = r_err_addr;
  assign rd_cnt          = r_rd_cnt;
  assign wr_cnt          = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_resp.sv
// ============================================================================
// tb_data_sram_resp : scoreboard testbench for data_sram_resp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_sram_resp;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        addr_err;
  logic [31:0] err_addr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  data_sram_resp #(.ADDR_W(10), .BASE(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .addr_err        (addr_err),
    .err_addr        (err_addr),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
  logic [15:0] m_rd;
  logic [15:0] m_wr;
  logic        m_err;
  logic [31:0] m_err_addr;

  task automatic reset_model();
    m_rdata    = 32'h0;
    m_rd       = 16'h0;
    m_wr       = 16'h0;
    m_err      = 1'b0;
    m_err_addr = 32'h0;
    exp_q.delete();
  endtask

  // One access per clock; expected read data is queued at drive time and
  // popped once the DUT has registered the response.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit          inwin;
    int          idx;
    logic [31:0] w;
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    inwin = (addr[31:12] == 20'h0);
    idx   = int'(addr[11:2]);
    if (inwin) begin
      if (wen != 4'h0) begin
        w = m_mem.exists(idx) ? m_mem[idx] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++)
          if (wen[i]) w[8*i +: 8] = wdata[8*i +: 8];
        m_mem[idx] = w;
        if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
      end else begin
        exp_q.push_back(m_mem.exists(idx) ? m_mem[idx] : 32'hxxxx_xxxx);
        if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
      end
    end else begin
      if (!m_err) begin
        m_err      = 1'b1;
        m_err_addr = addr;
      end
      if (wen == 4'h0) exp_q.push_back(32'h0);
    end
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    if (wen == 4'h0 && exp_q.size() > 0) m_rdata = exp_q.pop_front();
    n_tests++;
    if (data_sram_rdata !== m_rdata) begin
      n_fail++;
      $display("FAIL rdata addr=%h wen=%h got=%h exp=%h", addr, wen, data_sram_rdata, m_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_tests++;
    if ({data_sram_rdata, addr_err, err_addr, rd_cnt, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h/%b/%h/%h/%h exp=all zero",
               data_sram_rdata, addr_err, err_addr, rd_cnt, wr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    access(4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    access(4'h0, 32'h0000_0010, 32'h0);
    n_tests++;
    if (data_sram_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_read got=%h exp=%h", data_sram_rdata, 32'hDEAD_BEEF);
    end
    n_tests++;
    if (wr_cnt !== m_wr || rd_cnt !== m_rd || m_wr !== 16'd1 || m_rd !== 16'd1) begin
      n_fail++;
      $display("FAIL counters_1 got wr=%0d rd=%0d exp wr=1 rd=1", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_byte_lanes();
    access(4'b0010, 32'h0000_0011, 32'h0000_5500);
    access(4'h0, 32'h0000_0010, 32'h0);
    n_tests++;
    if (data_sram_rdata !== 32'hDEAD_55EF) begin
      n_fail++;
      $display("FAIL byte_lane got=%h exp=%h", data_sram_rdata, 32'hDEAD_55EF);
    end
    access(4'b1001, 32'h0000_0010, 32'h1100_0022);
    access(4'h0, 32'h0000_0010, 32'h0);
  endtask

  task automatic test_back_to_back();
    access(4'hF, 32'h0000_0000, 32'd1);
    access(4'hF, 32'h0000_0004, 32'd2);
    access(4'hF, 32'h0000_0008, 32'd3);
    access(4'h0, 32'h0000_0000, 32'h0);
    access(4'h0, 32'h0000_0004, 32'h0);
    access(4'h0, 32'h0000_0008, 32'h0);
    n_tests++;
    if (data_sram_rdata !== 32'd3) begin
      n_fail++;
      $display("FAIL back_to_back_last got=%h exp=%h", data_sram_rdata, 32'd3);
    end
  endtask

  task automatic test_out_of_window();
    logic [15:0] rd0;
    logic [15:0] wr0;
    rd0 = m_rd;
    wr0 = m_wr;
    access(4'h0, 32'h0000_1000, 32'h0);
    access(4'hF, 32'h0000_2000, 32'hFFFF_FFFF);
    n_tests++;
    if (addr_err !== 1'b1 || err_addr !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL addr_err got=%b/%h exp=1/%h", addr_err, err_addr, 32'h0000_1000);
    end
    n_tests++;
    if (rd_cnt !== rd0 || wr_cnt !== wr0) begin
      n_fail++;
      $display("FAIL oow_counters got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_cnt, wr_cnt, rd0, wr0);
    end
    // 0x2000 aliases word 0 if the window check is broken.
    access(4'h0, 32'h0000_0000, 32'h0);
    n_tests++;
    if (err_addr !== m_err_addr || addr_err !== m_err) begin
      n_fail++;
      $display("FAIL err_sticky got=%b/%h exp=%b/%h", addr_err, err_addr, m_err, m_err_addr);
    end
  endtask

  task automatic test_async_reset();
    access(4'hF, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h0000_0020;
    data_sram_wdata = 32'h1234_5678;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({data_sram_rdata, addr_err, err_addr, rd_cnt, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h/%b/%h/%h/%h exp=all zero",
               data_sram_rdata, addr_err, err_addr, rd_cnt, wr_cnt);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({data_sram_rdata, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got rdata=%h wr=%0d exp=0", data_sram_rdata, wr_cnt);
    end
    @(negedge clk);
    rst          = 1'b0;
    data_sram_en = 1'b0;
    reset_model();
    access(4'h0, 32'h0000_0020, 32'h0);
    n_tests++;
    if (data_sram_rdata !== 32'hCAFE_F00D || rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mem_kept got=%h rd=%0d wr=%0d exp=%h rd=1 wr=0",
               data_sram_rdata, rd_cnt, wr_cnt, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65537; i++) begin
      access(4'h0, {20'h0, i[9:0], 2'b00} & 32'h0000_000C, 32'h0);
    end
    n_tests++;
    if (rd_cnt !== m_rd || rd_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL rd_saturate got=%h exp=%h", rd_cnt, 16'hFFFF);
    end
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst             = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    reset_model();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_window();
    test_async_reset();
    // Word 0xC is read by the saturation loop, so give it a known value.
    access(4'hF, 32'h0000_000C, 32'h0BAD_F00D);
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
